// File: rtl/fq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fq_pkg
// Description : Shared widths, FSM state encoding and the clamp helper for
//               the frequency tuning register.
// Contents    : FQ_W, DELTA_W, fq_tuner_state_t, fq_clamp()
// Revision    : 1.0 - initial release
// ============================================================================
package fq_pkg;

    localparam int FQ_W    = 32;   // frequency register width, Hz
    localparam int DELTA_W = 10;   // detent accumulator width

    typedef enum logic [1:0] {
        FQ_IDLE  = 2'd0,
        FQ_SCALE = 2'd1,
        FQ_APPLY = 2'd2,
        FQ_SEND  = 2'd3
    } fq_tuner_state_t;

    // Clamp a wide signed sum into [fq_min, fq_max]. The bounds are legal
    // frequencies, so the result always fits the frequency register.
    function automatic logic [FQ_W-1:0] fq_clamp(
        input logic signed [63:0] sum,
        input logic signed [63:0] fq_min,
        input logic signed [63:0] fq_max
    );
        logic signed [63:0] r;
        if (sum < fq_min) begin
            r = fq_min;
        end else if (sum > fq_max) begin
            r = fq_max;
        end else begin
            r = sum;
        end
        return r[FQ_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fq_step_scaler.sv
`default_nettype none
// ============================================================================
// Module      : fq_step_scaler
// Description : Registered delta x step multiply with optional acceleration
//               shift. One cycle of latency: prod is valid the cycle after en.
// Ports       : aclk, reset      - clock, synchronous active-high reset
//               en               - load a new product this cycle
//               delta            - signed detent count
//               step_sel         - selects STEP0..STEP3
//               prod             - registered signed product
// Revision    : 1.0 - initial release
// ============================================================================
module fq_step_scaler
    import fq_pkg::*;
#(
    parameter logic [23:0] STEP0        = 24'd1,
    parameter logic [23:0] STEP1        = 24'd10,
    parameter logic [23:0] STEP2        = 24'd100,
    parameter logic [23:0] STEP3        = 24'd1000,
    parameter int          ACCEL_THRESH = 4,
    parameter int          ACCEL_SHIFT  = 3,
    parameter bit          ACCEL_ON     = 1'b0,
    parameter int          PROD_W       = 35
) (
    input  logic                      aclk,
    input  logic                      reset,
    input  logic                      en,
    input  logic signed [DELTA_W-1:0] delta,
    input  logic [1:0]                step_sel,
    output logic signed [PROD_W-1:0]  prod
);

    logic [23:0]               w_step;
    logic signed [34:0]        w_base;
    logic [DELTA_W-1:0]        w_abs;
    logic                      w_accel;
    logic signed [PROD_W-1:0]  w_ext;
    logic signed [PROD_W-1:0]  w_scaled;

    always_comb begin
        case (step_sel)
            2'd0:    w_step = STEP0;
            2'd1:    w_step = STEP1;
            2'd2:    w_step = STEP2;
            default: w_step = STEP3;
        endcase
        // Step is zero-extended to keep it positive in the signed multiply.
        w_base   = delta * $signed({1'b0, w_step});
        // |-512| = 512 still fits DELTA_W bits when read as unsigned.
        w_abs    = delta[DELTA_W-1] ? DELTA_W'(-delta) : DELTA_W'(delta);
        w_accel  = ACCEL_ON && ({{(32-DELTA_W){1'b0}}, w_abs} >= ACCEL_THRESH);
        w_ext    = PROD_W'(w_base);
        w_scaled = w_ext <<< ACCEL_SHIFT;
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            prod <= '0;
        end else if (en) begin
            prod <= w_accel ? w_scaled : w_ext;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fq_tuner.sv
`default_nettype none
// ============================================================================
// Module      : fq_tuner
// Description : Frequency tuning register. Captures signed detent counts from
//               the dial poller on each rising edge of inc_valid, scales them
//               by the selected step, accumulates into a clamped frequency
//               and publishes every change over a valid/ready handshake.
//               Detents arriving while busy are summed into a saturating
//               pending count and serviced when the FSM returns to idle.
// Config      : FQ_TUNER_ACCEL_EN - when defined, deltas with
//               |fq_inc| >= ACCEL_THRESH are shifted left by ACCEL_SHIFT.
// Ports       : aclk, reset      - clock, synchronous active-high reset
//               fq_inc           - signed detents since last poll
//               inc_valid        - dial output valid (level)
//               step_sel         - step size select
//               freq_out         - current frequency, Hz
//               freq_valid       - freq_out offered downstream
//               freq_ready       - downstream accepts
//               at_limit         - last update was clamped
// Revision    : 1.0 - initial release
// ============================================================================
module fq_tuner
    import fq_pkg::*;
#(
    parameter logic [FQ_W-1:0] FQ_MIN       = 32'd100_000,
    parameter logic [FQ_W-1:0] FQ_MAX       = 32'd30_000_000,
    parameter logic [FQ_W-1:0] FQ_RESET     = 32'd7_000_000,
    parameter logic [23:0]     STEP0        = 24'd1,
    parameter logic [23:0]     STEP1        = 24'd10,
    parameter logic [23:0]     STEP2        = 24'd100,
    parameter logic [23:0]     STEP3        = 24'd1000,
    parameter int              ACCEL_THRESH = 4,
    parameter int              ACCEL_SHIFT  = 3
) (
    input  logic            aclk,
    input  logic            reset,
    input  logic [7:0]      fq_inc,
    input  logic            inc_valid,
    input  logic [1:0]      step_sel,
    output logic [FQ_W-1:0] freq_out,
    output logic            freq_valid,
    input  logic            freq_ready,
    output logic            at_limit
);

`ifdef FQ_TUNER_ACCEL_EN
    localparam bit c_ACCEL_ON = 1'b1;
`else
    localparam bit c_ACCEL_ON = 1'b0;
`endif
    localparam int c_PROD_W = 35 + (c_ACCEL_ON ? ACCEL_SHIFT : 0);
    localparam int c_SUM_W  = c_PROD_W + 1;

    fq_tuner_state_t r_state;
    fq_tuner_state_t w_state_nxt;

    logic                      r_inc_valid_q;
    logic                      r_boot;         // announce FQ_RESET once after reset
    logic signed [DELTA_W-1:0] r_delta;
    logic [1:0]                r_step_sel;
    logic signed [DELTA_W-1:0] r_pending;
    logic                      r_pending_vld;
    logic [FQ_W-1:0]           r_freq;
    logic                      r_at_limit;

    logic                      w_event;
    logic                      w_busy;
    logic signed [DELTA_W-1:0] w_inc_ext;
    logic signed [DELTA_W:0]   w_pend_sum;
    logic signed [DELTA_W-1:0] w_pend_sat;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [c_SUM_W-1:0] w_sum;
    logic signed [63:0]        w_sum64;
    logic [FQ_W-1:0]           w_freq_new;
    logic                      w_clamped;

    fq_step_scaler #(
        .STEP0        (STEP0),
        .STEP1        (STEP1),
        .STEP2        (STEP2),
        .STEP3        (STEP3),
        .ACCEL_THRESH (ACCEL_THRESH),
        .ACCEL_SHIFT  (ACCEL_SHIFT),
        .ACCEL_ON     (c_ACCEL_ON),
        .PROD_W       (c_PROD_W)
    ) u_scaler (
        .aclk     (aclk),
        .reset    (reset),
        .en       (r_state == FQ_SCALE),
        .delta    (r_delta),
        .step_sel (r_step_sel),
        .prod     (w_prod)
    );

    assign w_event   = inc_valid & ~r_inc_valid_q;
    // The boot announcement counts as busy so a capture then is not lost.
    assign w_busy    = (r_state != FQ_IDLE) || r_boot;
    assign w_inc_ext = {{(DELTA_W-8){fq_inc[7]}}, fq_inc};

    always_comb begin
        w_pend_sum = {r_pending[DELTA_W-1], r_pending} + {{(DELTA_W-7){fq_inc[7]}}, fq_inc};
        if (w_pend_sum > 11'sd511) begin
            w_pend_sat = 10'b01_1111_1111;
        end else if (w_pend_sum < -11'sd512) begin
            w_pend_sat = 10'b10_0000_0000;
        end else begin
            w_pend_sat = w_pend_sum[DELTA_W-1:0];
        end
    end

    always_comb begin
        w_sum      = {{(c_SUM_W-FQ_W){1'b0}}, r_freq} + {w_prod[c_PROD_W-1], w_prod};
        w_sum64    = {{(64-c_SUM_W){w_sum[c_SUM_W-1]}}, w_sum};
        w_freq_new = fq_clamp(w_sum64, {32'd0, FQ_MIN}, {32'd0, FQ_MAX});
        w_clamped  = (w_sum64 < $signed({32'd0, FQ_MIN})) ||
                     (w_sum64 > $signed({32'd0, FQ_MAX}));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FQ_IDLE: begin
                if (r_boot) begin
                    w_state_nxt = FQ_SEND;
                end else if (r_pending_vld || w_event) begin
                    w_state_nxt = FQ_SCALE;
                end
            end
            FQ_SCALE: w_state_nxt = FQ_APPLY;
            FQ_APPLY: w_state_nxt = (w_freq_new != r_freq) ? FQ_SEND : FQ_IDLE;
            FQ_SEND:  if (freq_ready) w_state_nxt = FQ_IDLE;
            default:  w_state_nxt = FQ_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state       <= FQ_IDLE;
            r_boot        <= 1'b1;
            r_inc_valid_q <= 1'b1;
            r_delta       <= '0;
            r_step_sel    <= '0;
            r_pending     <= '0;
            r_pending_vld <= 1'b0;
            r_freq        <= FQ_RESET;
            r_at_limit    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_inc_valid_q <= inc_valid;
            if (r_state == FQ_IDLE) begin
                r_boot <= 1'b0;
            end

            if (!w_busy) begin
                if (r_pending_vld) begin
                    // Older pending detents go first; a simultaneous new
                    // capture becomes the next pending count.
                    r_delta       <= r_pending;
                    r_step_sel    <= step_sel;
                    r_pending     <= w_event ? w_inc_ext : '0;
                    r_pending_vld <= w_event;
                end else if (w_event) begin
                    r_delta    <= w_inc_ext;
                    r_step_sel <= step_sel;
                end
            end else if (w_event) begin
                r_pending     <= w_pend_sat;
                r_pending_vld <= 1'b1;
            end

            if (r_state == FQ_APPLY) begin
                r_at_limit <= w_clamped;
                if (w_freq_new != r_freq) begin
                    r_freq <= w_freq_new;
                end
            end
        end
    end

    assign freq_out   = r_freq;
    assign freq_valid = (r_state == FQ_SEND);
    assign at_limit   = r_at_limit;

endmodule
`default_nettype wire
